dmem_access: RTL and testbench
==============================

# dmem_access

Data-memory access stage sitting directly downstream of `lsu`. It accepts one load or store request at a time and checks alignment. It drives a 64-bit word-addressed data-memory bus with a valid/grant request and a separate response. It returns sign- or zero-extended load data, or a store acknowledge, to the pipeline. It is a single-outstanding, non-pipelined engine.

## Interface
- No parameters; data path fixed at 64 bits, bus word 8 bytes.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle, request accepted when `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-justified.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_data` out 64: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: misaligned access; valid with `rsp_valid`.
- `mem_req` out 1: bus request, held until granted.
- `mem_we` out 1: write.
- `mem_addr` out 64: `req_addr` with bits [2:0] cleared.
- `mem_wdata` out 64: lane-shifted store data.
- `mem_wstrb` out 8: byte enables; 0 on reads.
- `mem_gnt` in 1: bus accepted request this cycle.
- `mem_rvalid` in 1: read data or write ack this cycle.
- `mem_rdata` in 64: read word.

## Operation
- **States:** IDLE, REQ, WAIT, RESP.
- **IDLE:** `req_ready`=1. On accept, register store, addr, wdata, size and unsigned.
  - Misaligned request (addr[0]≠0 for half, addr[1:0]≠0 for word, addr[2:0]≠0 for dword) → RESP with fault, and no bus activity.
  - Otherwise → REQ.
- **REQ:** `mem_req`=1 with stable address, we, wdata and wstrb.
  - `mem_gnt` && `mem_rvalid` in the same cycle → RESP.
  - `mem_gnt` alone → WAIT.
- **WAIT:** `mem_rvalid` → RESP, capturing `mem_rdata`.
- **RESP:** `rsp_valid`=1 for exactly one cycle → IDLE. There is no response back-pressure.
- **Store lanes:** off = addr[2:0].
  - `mem_wdata` = `req_wdata` << (8·off).
  - `mem_wstrb` = ((1<<(1<<size))−1) << off.
- **Load extract:**
  - Word = `mem_rdata` >> (8·off).
  - Keep the low 8/16/32/64 bits.
  - Extend from the top kept bit unless `req_unsigned`. Unsigned has no effect for dword.
- `rsp_fault`=1 only for the misaligned path; `rsp_data`=0 then.
- `mem_rvalid` outside REQ/WAIT is ignored.
- `mem_gnt` outside REQ is ignored.
- **Reset:** asynchronous, to IDLE from any state, including mid-transaction. Outstanding bus transactions are abandoned, and their late `mem_rvalid` is ignored.
- **Reset values:** `req_ready`=1; `rsp_valid`, `rsp_fault`, `mem_req`, `mem_we`=0; `rsp_data`, `mem_addr`, `mem_wdata`=0; `mem_wstrb`=0.

## Timing
- Accept at cycle 0. All outputs are registered or decoded from registered state; there is no combinational in→out path.
- `mem_req` is asserted in cycle 1.
- **Minimum load/store latency:** `mem_gnt` and `mem_rvalid` in cycle 1 → `rsp_valid` in cycle 2.
- **Separate grant and data:** gnt in cycle 1, rvalid in cycle 2 → `rsp_valid` in cycle 3.
- **Each extra stall cycle** of gnt or rvalid adds one cycle.
- **Fault:** `rsp_valid`+`rsp_fault` in cycle 1.
- `req_ready` is 0 from cycle 1 until the cycle after RESP. A new request is therefore accepted at the earliest in the cycle after `rsp_valid`.
- `mem_*` request outputs stay constant while `mem_req`=1 and `mem_gnt`=0.

## Test plan
- **Signed byte load:** load byte at addr 0x1003, size 0, signed; mem_rdata=0x0000_0000_8000_0000, gnt and rvalid in cycle 1 → `mem_addr`=0x1000 with `mem_wstrb`=0; `rsp_valid` in cycle 2 with `rsp_data`=0xFFFF_FFFF_FFFF_FF80. Repeat unsigned → 0x80.
- **Word store with stalls:** store word 0xDEADBEEF at 0x2004; gnt withheld 3 cycles → `mem_req` held stable 3 cycles with `mem_we`=1, `mem_wdata`=0xDEADBEEF_0000_0000 and `mem_wstrb`=0xF0; rvalid 2 cycles after gnt → `rsp_valid`, `rsp_data`=0.
- **Misaligned dword:** load dword at 0x3002 → no `mem_req`; `rsp_valid`=1 and `rsp_fault`=1 in cycle 1; `req_ready`=1 in cycle 2.
- **Back-to-back with early request:** two requests with `req_valid` held high → second accepted only the cycle after the first `rsp_valid`; spurious `mem_rvalid` pulses in IDLE cause no response.
- **Reset mid-transaction:** assert `rst` while in WAIT → all outputs at reset values immediately; a late `mem_rvalid` after deassert produces no `rsp_valid`.
- **Signed half load:** load half at 0x4006, signed, mem_rdata=0x7FFF_0000_0000_0000 → `rsp_data`=0x7FFF. The same read with 0x8001_… gives 0xFFFF_FFFF_FFFF_8001.

Source files
------------

// File: rtl/dmem_access.sv
// dmem_access: single-outstanding load/store engine between the LSU and a
// 64-bit word-addressed data-memory bus. Checks alignment, lane-shifts store
// data, and extracts/extends load data for the pipeline response.
module dmem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state;
    logic        fault_q;
    logic        store_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rsp_q;

    logic        accept;
    logic        misaligned;
    logic        capture;

    // Byte-enable pattern for an access of 2^size bytes starting at lane off.
    function automatic logic [7:0] lane_strobe(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    // Shift the addressed lane down, keep 8/16/32/64 bits, then sign- or zero-extend.
    function automatic logic [63:0] load_extract(input logic [63:0] rdata, input logic [2:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic signed [63:0] sh;
        logic [63:0]        res;
        sh = $signed(rdata >> {off, 3'b000});
        case (size)
            2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign accept = req_valid && (state == S_IDLE);

    // Natural alignment: half needs addr[0]=0, word addr[1:0]=0, dword addr[2:0]=0.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Read data / write ack is only meaningful once the bus has granted us.
    assign capture = mem_rvalid && (((state == S_REQ) && mem_gnt) || (state == S_WAIT));

    // Control FSM; reset abandons any outstanding bus transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    fault_q <= misaligned;
                    state   <= misaligned ? S_RESP : S_REQ;
                end
                S_REQ: if (mem_gnt) begin
                    state <= mem_rvalid ? S_RESP : S_WAIT;
                end
                S_WAIT: if (mem_rvalid) begin
                    state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request fields and response data; outputs are gated by state so these need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            store_q    <= req_store;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rsp_q      <= 64'd0;
        end else if (capture) begin
            rsp_q <= store_q ? 64'd0 : load_extract(mem_rdata, addr_q[2:0], size_q, unsigned_q);
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_fault = (state == S_RESP) && fault_q;
    assign rsp_data  = (state == S_RESP) ? rsp_q : 64'd0;

    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = mem_req ? {addr_q[63:3], 3'b000} : 64'd0;
    assign mem_wdata = mem_we ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
    assign mem_wstrb = mem_we ? lane_strobe(size_q, addr_q[2:0]) : 8'd0;

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed scenarios for dmem_access with hand-computed expectations.
module tb_dmem_access;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_access dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [63:0] a, input logic [63:0] wd,
                           input logic [1:0] sz, input logic uns);
        req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = uns;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_store = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        step();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if ({rsp_valid, rsp_fault, mem_req, mem_we} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {rsp_valid, rsp_fault, mem_req, mem_we}); end
        total++; if ({rsp_data, mem_addr, mem_wdata, mem_wstrb} !== 200'd0) begin bad++; $display("FAIL reset_data: got %h %h %h %h want 0", rsp_data, mem_addr, mem_wdata, mem_wstrb); end
        rst = 1'b0;
        step();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_byte_load(input logic uns, input logic [63:0] exp);
        set_req(1'b0, 64'h1003, 64'd0, 2'd0, uns);
        step();
        req_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL byte_req: got req=%b we=%b want 1 0", mem_req, mem_we); end
        total++; if (mem_addr !== 64'h1000) begin bad++; $display("FAIL byte_addr: got %h want 1000", mem_addr); end
        total++; if (mem_wstrb !== 8'h00) begin bad++; $display("FAIL byte_wstrb: got %h want 00", mem_wstrb); end
        total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL byte_c1: got ready=%b rsp=%b want 0 0", req_ready, rsp_valid); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) begin bad++; $display("FAIL byte_rsp: got v=%b f=%b want 1 0", rsp_valid, rsp_fault); end
        total++; if (rsp_data !== exp) begin bad++; $display("FAIL byte_data uns=%b: got %h want %h", uns, rsp_data, exp); end
        step();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL byte_after: got v=%b ready=%b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_word_store_stall;
        set_req(1'b1, 64'h2004, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b0);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL st_hold%0d_ctrl: got req=%b we=%b want 1 1", i, mem_req, mem_we); end
            total++; if (mem_addr !== 64'h2000 || mem_wdata !== 64'hDEAD_BEEF_0000_0000 || mem_wstrb !== 8'hF0) begin
                bad++; $display("FAIL st_hold%0d_bus: got a=%h d=%h s=%h want 2000 deadbeef00000000 f0", i, mem_addr, mem_wdata, mem_wstrb);
            end
            step();
        end
        total++; if (mem_req !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL st_c4: got req=%b rsp=%b want 1 0", mem_req, rsp_valid); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        total++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL st_wait: got req=%b rsp=%b want 0 0", mem_req, rsp_valid); end
        step();
        mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd0 || rsp_fault !== 1'b0) begin
            bad++; $display("FAIL st_rsp: got v=%b d=%h f=%b want 1 0 0", rsp_valid, rsp_data, rsp_fault);
        end
        step();
    endtask

    task automatic test_misaligned;
        set_req(1'b0, 64'h3002, 64'd0, 2'd3, 1'b0);
        step();
        req_valid = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_noreq: got %b want 0", mem_req); end
        total++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_data !== 64'd0) begin
            bad++; $display("FAIL mis_rsp: got v=%b f=%b d=%h want 1 1 0", rsp_valid, rsp_fault, rsp_data);
        end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mis_busy: got %b want 0", req_ready); end
        step();
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0) begin
            bad++; $display("FAIL mis_after: got ready=%b v=%b f=%b want 1 0 0", req_ready, rsp_valid, rsp_fault);
        end
    endtask

    task automatic test_back_to_back;
        set_req(1'b0, 64'h0000_0000_0000_0011, 64'd0, 2'd0, 1'b1);
        step();
        total++; if (mem_req !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL b2b_first: got req=%b ready=%b want 1 0", mem_req, req_ready); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0000_AB00;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hAB || req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_rsp1: got v=%b d=%h ready=%b want 1 ab 0", rsp_valid, rsp_data, req_ready);
        end
        step();
        total++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL b2b_idle: got ready=%b req=%b want 1 0", req_ready, mem_req); end
        step();
        req_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h10) begin bad++; $display("FAIL b2b_second: got req=%b a=%h want 1 10", mem_req, mem_addr); end
        mem_gnt = 1'b1; mem_rdata = 64'h0000_0000_0000_CD00;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hCD) begin bad++; $display("FAIL b2b_rsp2: got v=%b d=%h want 1 cd", rsp_valid, rsp_data); end
        step();
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_gnt = 1'b1;
            step();
            total++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL b2b_spurious%0d: got v=%b req=%b want 0 0", i, rsp_valid, mem_req); end
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        set_req(1'b1, 64'h6000, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
        step();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        total++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_wait: got req=%b v=%b ready=%b want 0 0 0", mem_req, rsp_valid, req_ready);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1 || {rsp_valid, rsp_fault, mem_req, mem_we} !== 4'b0) begin
            bad++; $display("FAIL rstmid_ctrl: got ready=%b ctrl=%b want 1 0000", req_ready, {rsp_valid, rsp_fault, mem_req, mem_we});
        end
        total++; if ({rsp_data, mem_addr, mem_wdata, mem_wstrb} !== 200'd0) begin
            bad++; $display("FAIL rstmid_data: got %h %h %h %h want 0", rsp_data, mem_addr, mem_wdata, mem_wstrb);
        end
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hFF;
        step();
        mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_late1: got %b want 0", rsp_valid); end
        step();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_late2: got v=%b ready=%b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_load_ext(input logic [63:0] a, input logic [1:0] sz, input logic uns,
                                 input logic [63:0] rd, input logic [63:0] exp);
        set_req(1'b0, a, 64'd0, sz, uns);
        step();
        req_valid = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
            bad++; $display("FAIL ext a=%h sz=%0d: got v=%b d=%h want 1 %h", a, sz, rsp_valid, rsp_data, exp);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_byte_load(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        test_byte_load(1'b1, 64'h0000_0000_0000_0080);
        test_word_store_stall();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_load_ext(64'h4006, 2'd1, 1'b0, 64'h7FFF_0000_0000_0000, 64'h0000_0000_0000_7FFF);
        test_load_ext(64'h4006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        test_load_ext(64'h5004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        test_load_ext(64'h5000, 2'd3, 1'b1, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
